vga_scan_timer: RTL and testbench

- Display-side counterpart of the sprite/digit renderers: generates the x_cnt/y_cnt raster scan that the renderers decode.
- Samples their OR-combined r/g/b_data and drives the DE2-115 ADV7123 DAC pins (RGB, HS, VS, BLANK_N, SYNC_N, CLK) with matched one-pixel pipeline alignment.
- Sits between the 50 MHz board clock and the top-level VGA pins.

---
 rtl/vga_scan_timer.sv | 134 +++++++++++++
 tb/tb_vga_scan_timer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timer.sv
// VGA raster scan generator and ADV7123 DAC output stage with a one-pixel aligned data/sync pipeline.
// Optional build macro VGA_SCAN_TEST_PATTERN_EN replaces renderer data with eight vertical colour bars.
module vga_scan_timer #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_data,
  input  logic [7:0] g_data,
  input  logic [7:0] b_data,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  output logic       pix_stb,
  output logic       frame_start,
  output logic       vga_clk,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = $clog2(CLK_DIV);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic          active;
  logic          hs_region;
  logic          vs_region;
  logic [7:0]    pix_r;
  logic [7:0]    pix_g;
  logic [7:0]    pix_b;

  assign pix_stb        = (prescaler == PRE_LAST);
  assign prescaler_next = pix_stb ? '0 : prescaler + PRE_ONE;
  assign frame_start    = pix_stb && (x_cnt == 10'd0) && (y_cnt == 10'd0);
  assign vga_sync_n     = 1'b0;

  // vga_clk is derived from the post-update prescaler so it falls on the strobe edge,
  // leaving DAC data stable across its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      vga_clk   <= 1'b0;
    end else begin
      prescaler <= prescaler_next;
      vga_clk   <= (prescaler_next >= PRE_HALF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= 10'd0;
      y_cnt <= 10'd0;
    end else if (pix_stb) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= 10'd0;
        y_cnt <= (y_cnt == Y_LAST) ? 10'd0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  assign active    = (x_cnt < H_ACT) && (y_cnt < V_ACT);
  assign hs_region = (x_cnt >= HS_START) && (x_cnt < HS_END);
  assign vs_region = (y_cnt >= VS_START) && (y_cnt < VS_END);

`ifdef VGA_SCAN_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0] bar_idx;
  logic       unused_data;

  assign bar_idx     = x_cnt / BAR_W;
  assign unused_data = ^{r_data, g_data, b_data, bar_idx[9:3]};

  // Bars run white, yellow, cyan, green, magenta, red, blue, black: each colour is one inverted index bit.
  assign pix_r = {8{~bar_idx[1]}};
  assign pix_g = {8{~bar_idx[2]}};
  assign pix_b = {8{~bar_idx[0]}};
`else
  assign pix_r = r_data;
  assign pix_g = g_data;
  assign pix_b = b_data;
`endif

  // Data, blanking and syncs are all captured for the same pre-increment pixel, keeping them aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_blank_n <= 1'b0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
    end else if (pix_stb) begin
      vga_r       <= active ? pix_r : 8'h00;
      vga_g       <= active ? pix_g : 8'h00;
      vga_b       <= active ? pix_b : 8'h00;
      vga_blank_n <= active;
      vga_hs      <= hs_region ? HS_POL : ~HS_POL;
      vga_vs      <= vs_region ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Testbench for vga_scan_timer: table vectors plus a per-pixel scoreboard over a shortened frame.
// Build with VGA_SCAN_TEST_PATTERN_EN defined to check the colour-bar variant.
module tb_vga_scan_timer;

  localparam int CLK_DIV    = 2;
  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_ACTIVE   = 8;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 2;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX  = H_TOTAL * V_TOTAL;
  localparam int FRAME_CLKS = FRAME_PIX * CLK_DIV;

  // Packed as {r, g, b, blank_n, hs, vs}; syncs idle high with both polarities 0.
  localparam logic [26:0] RESET_OUT = {24'h000000, 1'b0, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic [7:0] g_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic       pix_stb;
  logic       frame_start;
  logic       vga_clk;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;

  vga_scan_timer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_stb(pix_stb), .frame_start(frame_start),
    .vga_clk(vga_clk), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
    logic       bl, hs, vs;
  } vec_t;

  typedef struct {
    logic [26:0] val;
    int          pos;
    string       tag;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          fs_seen[$];
  logic [26:0] hold_val;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          clk_n = 0;
  bit          count_en = 1'b0;
  int          hs_low_n = 0;
  int          blank_hi_n = 0;
  int          vs_low_n = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    tests_run++;
    if (act !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: wait bound expired at clk %0d", name, clk_n);
  endtask

  task automatic add_vec(input int x, y, input logic [7:0] r, g, b, er, eg, eb,
                         input logic bl, hs, vs);
    vec_t v;
    v.x = x; v.y = y; v.r = r; v.g = g; v.b = b;
    v.er = er; v.eg = eg; v.eb = eb; v.bl = bl; v.hs = hs; v.vs = vs;
    vecs.push_back(v);
  endtask

  function automatic logic [26:0] dut_out();
    return {vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs};
  endfunction

  function automatic logic [31:0] dut_scan();
    return {8'h00, pix_stb, frame_start, vga_clk, vga_sync_n, y_cnt, x_cnt};
  endfunction

  // Scan position derived purely from the number of clocks since reset release.
  function automatic int cur_pos();
    return clk_n / CLK_DIV;
  endfunction

  function automatic int cur_x();
    return cur_pos() % H_TOTAL;
  endfunction

  function automatic int cur_y();
    return (cur_pos() / H_TOTAL) % V_TOTAL;
  endfunction

  function automatic bit at_stb();
    return (clk_n % CLK_DIV) == (CLK_DIV - 1);
  endfunction

  function automatic logic [26:0] model_out(input int x, y, input logic [7:0] r, g, b);
    logic        act;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    act = (x < H_ACTIVE) && (y < V_ACTIVE);
    rgb = 24'h000000;
    if (act) begin
`ifdef VGA_SCAN_TEST_PATTERN_EN
      case (x / (H_ACTIVE / 8))
        0:       rgb = 24'hFFFFFF;
        1:       rgb = 24'hFFFF00;
        2:       rgb = 24'h00FFFF;
        3:       rgb = 24'h00FF00;
        4:       rgb = 24'hFF00FF;
        5:       rgb = 24'hFF0000;
        6:       rgb = 24'h0000FF;
        default: rgb = 24'h000000;
      endcase
`else
      rgb = {r, g, b};
`endif
    end
    hs = !((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC));
    vs = !((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC));
    return {rgb, act, hs, vs};
  endfunction

  // One clock: check scan outputs, drive data (sampled only on strobe clocks), then check the DAC side.
  task automatic apply_stimulus(input bit has_vec, input vec_t v, input string tag);
    exp_t       e;
    bit         pushed;
    int         x;
    int         y;
    logic [7:0] r, g, b;
    x = cur_x();
    y = cur_y();
    check_output($sformatf("scan@%0d", clk_n), dut_scan(),
                 {8'h00, at_stb(), at_stb() && x == 0 && y == 0,
                  (clk_n % CLK_DIV) >= (CLK_DIV / 2), 1'b0, 10'(y), 10'(x)});
    if (frame_start === 1'b1) fs_seen.push_back(clk_n);
    pushed = at_stb();
    if (pushed && has_vec) begin
      r = v.r; g = v.g; b = v.b;
      e.val = {v.er, v.eg, v.eb, v.bl, v.hs, v.vs};
      e.tag = tag;
    end else begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      e.val = model_out(x, y, r, g, b);
      e.tag = $sformatf("pix x=%0d y=%0d", x, y);
    end
    e.pos = cur_pos();
    if (pushed) sb.push_back(e);
    r_data = r;
    g_data = g;
    b_data = b;
    @(posedge clk);
    #1;
    clk_n++;
    if (pushed) begin
      e = sb.pop_front();
      check_output(e.tag, {5'h00, dut_out()}, {5'h00, e.val});
      hold_val = e.val;
      if (count_en && e.pos < FRAME_PIX) begin
        if (vga_hs === 1'b0) hs_low_n++;
        if (vga_vs === 1'b0) vs_low_n++;
        if (vga_blank_n === 1'b1) blank_hi_n++;
      end
    end else begin
      check_output($sformatf("hold@%0d", clk_n), {5'h00, dut_out()}, {5'h00, hold_val});
    end
  endtask

  initial begin
    vec_t none;
    int   guard;
    int   first_fs;

`ifdef VGA_SCAN_TEST_PATTERN_EN
    add_vec(  0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    add_vec( 80, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
    add_vec(400, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    add_vec(639, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
`else
    add_vec(  0, 0, 8'h5A, 8'hA5, 8'h3C, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);
    add_vec(639, 0, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 1'b1);
`endif
    add_vec(655, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    add_vec(656, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    add_vec(751, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    add_vec(752, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    add_vec(  5, 7, 8'hAB, 8'h12, 8'hCD, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
`else
    add_vec(  5, 7, 8'hAB, 8'h12, 8'hCD, 8'hAB, 8'h12, 8'hCD, 1'b1, 1'b1, 1'b1);
`endif
    add_vec(640, 7, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    add_vec(  0, 8, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    add_vec(  0, 10, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    add_vec(799, 11, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    add_vec(  0, 12, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    add_vec(799, 13, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    none = vecs[0];

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs", {5'h00, dut_out()}, {5'h00, RESET_OUT});
    check_output("reset_scan", dut_scan(), 32'h0);

    rst = 1'b0;
    clk_n = 0;
    hold_val = RESET_OUT;
    count_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      guard = 0;
      while (!(at_stb() && cur_x() == vecs[i].x && cur_y() == vecs[i].y) && guard < FRAME_CLKS) begin
        apply_stimulus(1'b0, none, "");
        guard++;
      end
      if (guard >= FRAME_CLKS)
        timeout_fail($sformatf("reach_vec%0d", i));
      else
        apply_stimulus(1'b1, vecs[i], $sformatf("vec%0d x=%0d y=%0d", i, vecs[i].x, vecs[i].y));
    end

    while (clk_n < FRAME_CLKS + 4) apply_stimulus(1'b0, none, "");
    count_en = 1'b0;
    check_output("hs_low_strobes", hs_low_n, H_SYNC * V_TOTAL);
    check_output("vs_low_strobes", vs_low_n, V_SYNC * H_TOTAL);
    check_output("blank_high_strobes", blank_hi_n, H_ACTIVE * V_ACTIVE);
    check_output("frame_start_count", fs_seen.size(), 2);
    if (fs_seen.size() == 2)
      check_output("frame_start_period", fs_seen[1] - fs_seen[0], FRAME_CLKS);

    // Mid-frame asynchronous reset while the strobe is high at x=300, y=5.
    guard = 0;
    while (!(at_stb() && cur_x() == 300 && cur_y() == 5) && guard < FRAME_CLKS) begin
      apply_stimulus(1'b0, none, "");
      guard++;
    end
    if (guard >= FRAME_CLKS) timeout_fail("reach_reset_point");
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_outputs", {5'h00, dut_out()}, {5'h00, RESET_OUT});
    check_output("async_reset_scan", dut_scan(), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_output("held_reset_outputs", {5'h00, dut_out()}, {5'h00, RESET_OUT});
    check_output("held_reset_scan", dut_scan(), 32'h0);

    rst = 1'b0;
    clk_n = 0;
    sb.delete();
    fs_seen.delete();
    hold_val = RESET_OUT;
    repeat (8) apply_stimulus(1'b0, none, "");
    first_fs = -1;
    if (fs_seen.size() > 0) first_fs = fs_seen[0];
    check_output("restart_frame_start_clk", first_fs, 1);
    repeat (2 * H_TOTAL * CLK_DIV) apply_stimulus(1'b0, none, "");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
